// File: rtl/time_set_rtc.sv
// Settable real-time clock: four packed time fields loaded from a shared bus
// on rising strobes, advanced by a prescaled tick with a full carry chain.
module time_set_rtc #(
    parameter int unsigned FIELD_W  = 8,
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned FRAC_MAX = 99,
    parameter int unsigned SEC_MAX  = 59,
    parameter int unsigned MIN_MAX  = 59,
    parameter int unsigned HOUR_MAX = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FIELD_W-1:0]   time_in,
    input  logic                 set_frac,
    input  logic                 set_hour,
    input  logic                 set_minute,
    input  logic                 set_second,
    input  logic                 run,
    output logic [4*FIELD_W-1:0] time_out,
    output logic                 tick,
    output logic                 rollover,
    output logic                 set_err
);

    localparam int unsigned PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [FIELD_W-1:0] FRAC_LIM = FIELD_W'(FRAC_MAX);
    localparam logic [FIELD_W-1:0] SEC_LIM  = FIELD_W'(SEC_MAX);
    localparam logic [FIELD_W-1:0] MIN_LIM  = FIELD_W'(MIN_MAX);
    localparam logic [FIELD_W-1:0] HOUR_LIM = FIELD_W'(HOUR_MAX);

    // Strobe bit order: [3]=frac, [2]=hour, [1]=minute, [0]=second
    logic [3:0]         strobe;
    logic [3:0]         strobe_prev;
    logic [3:0]         rise;
    logic [3:0]         in_range;
    logic [3:0]         load;

    logic [FIELD_W-1:0] frac_q, hour_q, minute_q, second_q;
    logic [FIELD_W-1:0] frac_d, hour_d, minute_d, second_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               adv;
    logic               carry_sec, carry_min, carry_hour, wrap_day;
    logic               err_d;

    assign strobe   = {set_frac, set_hour, set_minute, set_second};
    assign time_out = {frac_q, hour_q, minute_q, second_q};

    // Edge detection, range check and per-field load enables
    always_comb begin
        rise     = strobe & ~strobe_prev;
        in_range = {time_in <= FRAC_LIM, time_in <= HOUR_LIM,
                    time_in <= MIN_LIM,  time_in <= SEC_LIM};
        load     = rise & in_range;
        err_d    = |(rise & ~in_range);
    end

    // Prescaler next value and advance strobe; any load restarts the count
    always_comb begin
        adv     = run && (presc_q == PRESC_LAST);
        presc_d = presc_q;
        if (|load) begin
            presc_d = '0;
        end else if (run) begin
            presc_d = adv ? '0 : presc_q + PRESC_W'(1);
        end
    end

    // Carry chain; a field being loaded swallows the carry coming into it
    always_comb begin
        carry_sec  = adv && (frac_q == FRAC_LIM) && !load[3];
        carry_min  = carry_sec && (second_q == SEC_LIM) && !load[0];
        carry_hour = carry_min && (minute_q == MIN_LIM) && !load[1];
        wrap_day   = carry_hour && (hour_q == HOUR_LIM) && !load[2];

        frac_d   = frac_q;
        second_d = second_q;
        minute_d = minute_q;
        hour_d   = hour_q;

        if (load[3])        frac_d = time_in;
        else if (adv)       frac_d = (frac_q == FRAC_LIM) ? '0 : frac_q + FIELD_W'(1);

        if (load[0])        second_d = time_in;
        else if (carry_sec) second_d = (second_q == SEC_LIM) ? '0 : second_q + FIELD_W'(1);

        if (load[1])        minute_d = time_in;
        else if (carry_min) minute_d = (minute_q == MIN_LIM) ? '0 : minute_q + FIELD_W'(1);

        if (load[2])         hour_d = time_in;
        else if (carry_hour) hour_d = (hour_q == HOUR_LIM) ? '0 : hour_q + FIELD_W'(1);
    end

    // State and output registers; strobe history resets high to block a held strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_prev <= 4'b1111;
            presc_q     <= '0;
            frac_q      <= '0;
            hour_q      <= '0;
            minute_q    <= '0;
            second_q    <= '0;
            tick        <= 1'b0;
            rollover    <= 1'b0;
            set_err     <= 1'b0;
        end else begin
            strobe_prev <= strobe;
            presc_q     <= presc_d;
            frac_q      <= frac_d;
            hour_q      <= hour_d;
            minute_q    <= minute_d;
            second_q    <= second_d;
            tick        <= adv;
            rollover    <= wrap_day;
            set_err     <= err_d;
        end
    end

endmodule

// File: tb/tb_time_set_rtc.sv
// Directed bench for time_set_rtc with a short prescaler (TICK_DIV=4).
module tb_time_set_rtc;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  time_in;
    logic        set_frac, set_hour, set_minute, set_second;
    logic        run;
    logic [31:0] time_out;
    logic        tick, rollover, set_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  set;     // {frac, hour, minute, second}
        logic [7:0]  tin;
        logic [31:0] exp_out;
        logic        exp_err;
    } vec_t;

    vec_t vecs [19];

    time_set_rtc #(
        .FIELD_W(8), .TICK_DIV(4), .FRAC_MAX(99),
        .SEC_MAX(59), .MIN_MAX(59), .HOUR_MAX(23)
    ) dut (
        .clk(clk), .rst(rst), .time_in(time_in),
        .set_frac(set_frac), .set_hour(set_hour),
        .set_minute(set_minute), .set_second(set_second),
        .run(run), .time_out(time_out), .tick(tick),
        .rollover(rollover), .set_err(set_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_set(input logic [3:0] s);
        {set_frac, set_hour, set_minute, set_second} = s;
    endtask

    task automatic load_field(input logic [3:0] s, input logic [7:0] v);
        drive_set(s);
        time_in = v;
        cyc();
        drive_set(4'b0000);
        cyc();
    endtask

    task automatic count_to_tick(input int maxc, output int n);
        n = 0;
        while (n < maxc) begin
            cyc();
            n++;
            if (tick) break;
        end
    endtask

    initial begin
        int n;
        logic seen;

        vecs[0]  = '{4'b0000,   0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{4'b0010,  10, 32'h0000_0A00, 1'b0};
        vecs[2]  = '{4'b0000,  60, 32'h0000_0A00, 1'b0};
        vecs[3]  = '{4'b0010,  60, 32'h0000_0A00, 1'b1};
        vecs[4]  = '{4'b0000,  60, 32'h0000_0A00, 1'b0};
        vecs[5]  = '{4'b0010,  59, 32'h0000_3B00, 1'b0};
        vecs[6]  = '{4'b0000,   0, 32'h0000_3B00, 1'b0};
        vecs[7]  = '{4'b0101,  12, 32'h000C_3B0C, 1'b0};
        vecs[8]  = '{4'b0000,  12, 32'h000C_3B0C, 1'b0};
        vecs[9]  = '{4'b0101,  30, 32'h000C_3B1E, 1'b1};
        vecs[10] = '{4'b0000,  30, 32'h000C_3B1E, 1'b0};
        vecs[11] = '{4'b0001,   5, 32'h000C_3B05, 1'b0};
        vecs[12] = '{4'b0001,   6, 32'h000C_3B05, 1'b0};
        vecs[13] = '{4'b0001,   7, 32'h000C_3B05, 1'b0};
        vecs[14] = '{4'b0000,   7, 32'h000C_3B05, 1'b0};
        vecs[15] = '{4'b1000, 100, 32'h000C_3B05, 1'b1};
        vecs[16] = '{4'b0000,  99, 32'h000C_3B05, 1'b0};
        vecs[17] = '{4'b1000,  99, 32'h630C_3B05, 1'b0};
        vecs[18] = '{4'b0000,   0, 32'h630C_3B05, 1'b0};

        // Reset with set_second held high across release
        rst = 1'b1; run = 1'b0; time_in = 8'd9;
        drive_set(4'b0001);
        cyc(); cyc();
        check("reset_time", time_out, 32'h0);
        check("reset_flags", {29'd0, tick, rollover, set_err}, 32'h0);
        rst = 1'b0;
        repeat (3) cyc();
        check("held_across_reset", time_out, 32'h0);
        drive_set(4'b0000);
        cyc();

        // Table: range checks, held strobes, simultaneous loads (run=0)
        for (int i = 0; i < 19; i++) begin
            drive_set(vecs[i].set);
            time_in = vecs[i].tin;
            cyc();
            check($sformatf("vec%0d_time", i), time_out, vecs[i].exp_out);
            check($sformatf("vec%0d_err", i), {31'd0, set_err}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_tick", i), {31'd0, tick}, 32'h0);
        end

        // Full wrap: 99 23:59:59 -> 0 with tick and rollover
        load_field(4'b1000, 99);
        load_field(4'b0100, 23);
        load_field(4'b0010, 59);
        load_field(4'b0001, 59);
        check("wrap_preload", time_out, 32'h6317_3B3B);
        run = 1'b1;
        repeat (3) cyc();
        check("wrap_pre_tick", {31'd0, tick}, 32'h0);
        cyc();
        check("wrap_time", time_out, 32'h0);
        check("wrap_pulses", {30'd0, tick, rollover}, 32'h3);
        cyc();
        check("wrap_pulses_end", {30'd0, tick, rollover}, 32'h0);
        check("wrap_time_after", time_out, 32'h0);

        // Set vs carry: minute load on the advance edge blocks the carry into hour
        run = 1'b0;
        load_field(4'b1000, 99);
        load_field(4'b0100, 10);
        load_field(4'b0010, 59);
        load_field(4'b0001, 59);
        check("setcarry_preload", time_out, 32'h630A_3B3B);
        run = 1'b1;
        repeat (3) cyc();
        drive_set(4'b0010);
        time_in = 8'd5;
        cyc();
        drive_set(4'b0000);
        check("setcarry_time", time_out, 32'h000A_0500);
        check("setcarry_flags", {29'd0, tick, rollover, set_err}, 32'h4);
        count_to_tick(20, n);
        check("setcarry_next_tick", n, 4);
        check("setcarry_frac", time_out, 32'h010A_0500);

        // Hold: run=0 freezes fields and prescaler mid-count
        cyc(); cyc();
        run = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            cyc();
            if (tick) seen = 1'b1;
        end
        check("hold_time", time_out, 32'h010A_0500);
        check("hold_no_tick", {31'd0, seen}, 32'h0);
        run = 1'b1;
        count_to_tick(20, n);
        check("hold_resume_tick", n, 2);
        check("hold_resume_time", time_out, 32'h020A_0500);

        // A load mid-count restarts the prescaler
        cyc(); cyc();
        drive_set(4'b0001);
        time_in = 8'd7;
        cyc();
        drive_set(4'b0000);
        count_to_tick(20, n);
        check("load_restart_tick", n, 4);
        check("load_restart_time", time_out, 32'h030A_0507);

        // Async reset between clock edges
        cyc();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_time", time_out, 32'h0);
        check("async_rst_flags", {29'd0, tick, rollover, set_err}, 32'h0);
        cyc();
        rst = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
